// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch slice: machine widths, the bubble
// instruction and the fetch FSM state encoding.
package riscv_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    // addi x0, x0, 0
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    // FS_REQ   : request outstanding (or about to be issued)
    // FS_HOLD  : returned word parked in the skid buffer during a stall
    // FS_DRAIN : waiting to discard a response made stale by a redirect
    typedef enum logic [1:0] {
        FS_REQ   = 2'd0,
        FS_HOLD  = 2'd1,
        FS_DRAIN = 2'd2
    } fetch_state_e;

    // Force an address onto a 4-byte boundary.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_bubble   : replace contents with NOP_INSTR, valid=0 (PC kept)
//   i_load     : capture i_instr / i_pc with valid=1
//   (neither)  : hold current contents
//   o_instr, o_pc, o_valid : register contents presented to decode
module if_id_reg
    import riscv_pkg::*;
#(
    parameter logic [ILEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_bubble,
    input  logic            i_load,
    input  logic [ILEN-1:0] i_instr,
    input  logic [XLEN-1:0] i_pc,
    output logic [ILEN-1:0] o_instr,
    output logic [XLEN-1:0] o_pc,
    output logic            o_valid
);

    logic [ILEN-1:0] r_instr;
    logic [XLEN-1:0] r_pc;
    logic            r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= NOP_INSTR;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (i_bubble) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_instr <= i_instr;
            r_pc    <= i_pc;
            r_valid <= 1'b1;
        end
    end

    assign o_instr = r_instr;
    assign o_pc    = r_pc;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with a single outstanding memory request,
// a one-entry skid buffer for load-use stalls and branch redirect.
//   clk, rst_n              : clock, asynchronous active-low reset
//   hazard_detected         : stall from decode (hold PC and IF/ID)
//   flush, branch_target    : taken-branch redirect
//   imem_req, imem_addr     : fetch request to instruction memory
//   imem_rdata, imem_valid  : instruction memory response
//   if_id_instruction/pc/valid : IF/ID register towards decode
//   fetch_misaligned        : one-cycle pulse for a redirect target with bits[1:0]!=0
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 64'h0,
    parameter logic [ILEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hazard_detected,
    input  logic            flush,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            imem_valid,
    output logic [ILEN-1:0] if_id_instruction,
    output logic [XLEN-1:0] if_id_pc,
    output logic            if_id_valid,
    output logic            fetch_misaligned
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nx;
    logic            r_req;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nx;
    logic [XLEN-1:0] w_pc_inc;
    logic [ILEN-1:0] r_skid_instr;
    logic [ILEN-1:0] w_skid_instr_nx;
    logic [XLEN-1:0] r_skid_pc;
    logic [XLEN-1:0] w_skid_pc_nx;
    logic            r_skid_valid;
    logic            w_skid_valid_nx;
    logic            r_misaligned;
    logic            w_accept;
    logic            w_ifid_bubble;
    logic            w_ifid_load;
    logic [ILEN-1:0] w_ifid_instr;
    logic [XLEN-1:0] w_ifid_pc;

    // Wraps modulo 2^64 naturally.
    assign w_pc_inc = r_pc + 64'd4;

    // A response only counts while our request is actually on the bus;
    // r_req is low for the first cycle after reset, so stray valids there
    // are ignored too.
    assign w_accept = (r_state == FS_REQ) && r_req && imem_valid;

    always_comb begin
        w_state_nx      = r_state;
        w_pc_nx         = r_pc;
        w_skid_instr_nx = r_skid_instr;
        w_skid_pc_nx    = r_skid_pc;
        w_skid_valid_nx = r_skid_valid;
        w_ifid_bubble   = 1'b0;
        w_ifid_load     = 1'b0;
        w_ifid_instr    = imem_rdata;
        w_ifid_pc       = r_pc;

        if (flush) begin
            w_pc_nx         = align_word(branch_target);
            w_skid_instr_nx = NOP_INSTR;
            w_skid_pc_nx    = '0;
            w_skid_valid_nx = 1'b0;
            w_ifid_bubble   = 1'b1;
            unique case (r_state)
                FS_REQ:   w_state_nx = (r_req && !imem_valid) ? FS_DRAIN : FS_REQ;
                FS_HOLD:  w_state_nx = FS_REQ;
                FS_DRAIN: w_state_nx = imem_valid ? FS_REQ : FS_DRAIN;
                default:  w_state_nx = FS_REQ;
            endcase
        end else begin
            // With no stall, a cycle that delivers no word leaves a bubble
            // so decode never re-executes the previous instruction.
            unique case (r_state)
                FS_REQ: begin
                    if (w_accept) begin
                        if (hazard_detected) begin
                            w_skid_instr_nx = imem_rdata;
                            w_skid_pc_nx    = r_pc;
                            w_skid_valid_nx = 1'b1;
                            w_state_nx      = FS_HOLD;
                        end else begin
                            w_ifid_load = 1'b1;
                            w_pc_nx     = w_pc_inc;
                        end
                    end else if (!hazard_detected) begin
                        w_ifid_bubble = 1'b1;
                    end
                end
                FS_HOLD: begin
                    if (!hazard_detected) begin
                        w_ifid_load     = r_skid_valid;
                        w_ifid_bubble   = !r_skid_valid;
                        w_ifid_instr    = r_skid_instr;
                        w_ifid_pc       = r_skid_pc;
                        w_skid_valid_nx = 1'b0;
                        w_pc_nx         = w_pc_inc;
                        w_state_nx      = FS_REQ;
                    end
                end
                FS_DRAIN: begin
                    if (imem_valid) begin
                        w_state_nx = FS_REQ;
                    end
                    w_ifid_bubble = !hazard_detected;
                end
                default: begin
                    w_state_nx = FS_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= FS_REQ;
            r_req        <= 1'b0;
            r_pc         <= RESET_PC;
            r_skid_instr <= NOP_INSTR;
            r_skid_pc    <= '0;
            r_skid_valid <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_req        <= (w_state_nx == FS_REQ);
            r_pc         <= w_pc_nx;
            r_skid_instr <= w_skid_instr_nx;
            r_skid_pc    <= w_skid_pc_nx;
            r_skid_valid <= w_skid_valid_nx;
            r_misaligned <= flush && (branch_target[1:0] != 2'b00);
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_bubble (w_ifid_bubble),
        .i_load   (w_ifid_load),
        .i_instr  (w_ifid_instr),
        .i_pc     (w_ifid_pc),
        .o_instr  (if_id_instruction),
        .o_pc     (if_id_pc),
        .o_valid  (if_id_valid)
    );

    assign imem_req         = r_req;
    assign imem_addr        = r_pc;
    assign fetch_misaligned = r_misaligned;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a per-cycle vector table on a zero-wait
// memory, then hand sequences on a 2-cycle memory (redirect drain, stall
// without data) and an asynchronous reset mid-request.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        hazard_detected;
    logic        flush;
    logic [63:0] branch_target;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] if_id_instruction;
    logic [63:0] if_id_pc;
    logic        if_id_valid;
    logic        fetch_misaligned;

    int total;
    int bad;

    fetch_stage #(
        .RESET_PC  (64'h0),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .hazard_detected   (hazard_detected),
        .flush             (flush),
        .branch_target     (branch_target),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_rdata        (imem_rdata),
        .imem_valid        (imem_valid),
        .if_id_instruction (if_id_instruction),
        .if_id_pc          (if_id_pc),
        .if_id_valid       (if_id_valid),
        .fetch_misaligned  (fetch_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    function automatic logic [31:0] word_at(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_0000;
    endfunction

    logic [3:0]  mem_lat;
    logic        force_valid;
    logic        mem_pend;
    logic [3:0]  mem_cnt;
    logic [63:0] mem_paddr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_pend  <= 1'b0;
            mem_cnt   <= 4'd0;
            mem_paddr <= 64'd0;
        end else if (imem_valid) begin
            mem_pend <= 1'b0;
            mem_cnt  <= 4'd0;
        end else if (imem_req || mem_pend) begin
            if (!mem_pend) mem_paddr <= imem_addr;
            mem_pend <= 1'b1;
            mem_cnt  <= mem_cnt + 4'd1;
        end
    end

    always_comb begin
        imem_valid = force_valid |
                     (mem_pend ? (mem_cnt >= mem_lat) : (imem_req && (mem_lat == 4'd0)));
        imem_rdata = word_at(mem_pend ? mem_paddr : imem_addr);
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        hz;
        logic        fl;
        logic        fv;
        logic [63:0] tgt;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_v;
        logic [63:0] e_pc;
        logic        e_mis;
    } vec_t;

    vec_t tbl[20];

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] e_instr;
        bit          seen;
        bit          early;

        total = 0;
        bad   = 0;

        //               hz    fl    fv    tgt                     req   addr                    v     pc                      mis
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 64'h0,                 1'b1, 64'h0,                 1'b0, 64'h0,                 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 64'h0,                 1'b1, 64'h4,                 1'b1, 64'h0,                 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 64'h0,                 1'b1, 64'h8,                 1'b1, 64'h4,                 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 64'h0,                 1'b1, 64'hC,                 1'b1, 64'h8,                 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 64'h0,                 1'b1, 64'h10,                1'b1, 64'hC,                 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 64'h0,                 1'b0, 64'h10,                1'b1, 64'hC,                 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 64'h0,                 1'b0, 64'h10,                1'b1, 64'hC,                 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 64'h0,                 1'b0, 64'h10,                1'b1, 64'hC,                 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 64'h0,                 1'b1, 64'h14,                1'b1, 64'h10,                1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 64'h0,                 1'b1, 64'h18,                1'b1, 64'h14,                1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 64'h203,               1'b1, 64'h200,               1'b0, 64'h14,                1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 64'h0,                 1'b1, 64'h204,               1'b1, 64'h200,               1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 64'h0,                 1'b1, 64'h208,               1'b1, 64'h204,               1'b0};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 64'h0,                 1'b0, 64'h208,               1'b1, 64'h204,               1'b0};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 64'h40,                1'b1, 64'h40,                1'b0, 64'h204,               1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 64'h0,                 1'b1, 64'h44,                1'b1, 64'h40,                1'b0};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 64'h40,              1'b1};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 64'h0,                 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 64'h0,                 1'b1, 64'h0,                 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 64'h0,                 1'b1, 64'h4,                 1'b1, 64'h0,                 1'b0};

        rst_n           = 1'b0;
        hazard_detected = 1'b0;
        flush           = 1'b0;
        branch_target   = 64'h0;
        mem_lat         = 4'd0;
        force_valid     = 1'b0;

        // Reset values
        step();
        step();
        check("rst_req",   {63'd0, imem_req},         64'd0);
        check("rst_addr",  imem_addr,                 64'h0);
        check("rst_valid", {63'd0, if_id_valid},      64'd0);
        check("rst_instr", {32'd0, if_id_instruction}, {32'd0, NOP});
        check("rst_pc",    if_id_pc,                  64'h0);
        check("rst_mis",   {63'd0, fetch_misaligned}, 64'd0);

        @(negedge clk);
        rst_n = 1'b1;

        // Zero-wait vector table
        for (int i = 0; i < 20; i++) begin
            hazard_detected = tbl[i].hz;
            flush           = tbl[i].fl;
            force_valid     = tbl[i].fv;
            branch_target   = tbl[i].tgt;
            step();
            e_instr = tbl[i].e_v ? {32'd0, word_at(tbl[i].e_pc)} : {32'd0, NOP};
            check($sformatf("v%0d_req", i),   {63'd0, imem_req},          {63'd0, tbl[i].e_req});
            check($sformatf("v%0d_addr", i),  imem_addr,                  tbl[i].e_addr);
            check($sformatf("v%0d_valid", i), {63'd0, if_id_valid},       {63'd0, tbl[i].e_v});
            check($sformatf("v%0d_pc", i),    if_id_pc,                   tbl[i].e_pc);
            check($sformatf("v%0d_instr", i), {32'd0, if_id_instruction}, e_instr);
            check($sformatf("v%0d_mis", i),   {63'd0, fetch_misaligned},  {63'd0, tbl[i].e_mis});
        end
        hazard_detected = 1'b0;
        flush           = 1'b0;
        force_valid     = 1'b0;
        branch_target   = 64'h0;

        // 2-cycle memory: redirect while the request at 0x4 is outstanding
        mem_lat = 4'd2;
        step();
        check("lat_req0",  {63'd0, imem_req}, 64'd1);
        check("lat_addr0", imem_addr,         64'h4);
        flush         = 1'b1;
        branch_target = 64'h100;
        step();
        flush         = 1'b0;
        branch_target = 64'h0;
        check("drain_req",   {63'd0, imem_req},          64'd0);
        check("drain_valid", {63'd0, if_id_valid},       64'd0);
        check("drain_instr", {32'd0, if_id_instruction}, {32'd0, NOP});
        seen  = 0;
        early = 0;
        for (int c = 0; c < 8 && !seen; c++) begin
            step();
            if (if_id_valid) begin
                seen = 1;
                check("redir_pc",    if_id_pc,                   64'h100);
                check("redir_instr", {32'd0, if_id_instruction}, {32'd0, word_at(64'h100)});
                check("redir_next",  imem_addr,                  64'h104);
            end else if (imem_addr != 64'h100) begin
                early = 1;
            end
        end
        check("redir_seen",   {63'd0, seen},  64'd1);
        check("redir_stable", {63'd0, early}, 64'd0);

        // Stall while the 0x104 request is still waiting, then the word lands in HOLD
        hazard_detected = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("st%0d_req", c),   {63'd0, imem_req},    (c < 2) ? 64'd1 : 64'd0);
            check($sformatf("st%0d_addr", c),  imem_addr,            64'h104);
            check($sformatf("st%0d_valid", c), {63'd0, if_id_valid}, 64'd1);
            check($sformatf("st%0d_pc", c),    if_id_pc,             64'h100);
        end
        hazard_detected = 1'b0;
        step();
        check("rel_pc",    if_id_pc,                   64'h104);
        check("rel_instr", {32'd0, if_id_instruction}, {32'd0, word_at(64'h104)});
        check("rel_req",   {63'd0, imem_req},          64'd1);
        check("rel_addr",  imem_addr,                  64'h108);

        // Asynchronous reset in the middle of an outstanding request
        step();
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_req",   {63'd0, imem_req},          64'd0);
        check("arst_addr",  imem_addr,                  64'h0);
        check("arst_valid", {63'd0, if_id_valid},       64'd0);
        check("arst_instr", {32'd0, if_id_instruction}, {32'd0, NOP});
        check("arst_pc",    if_id_pc,                   64'h0);
        mem_lat = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_req",  {63'd0, imem_req}, 64'd1);
        check("post_addr", imem_addr,         64'h0);
        step();
        check("post_valid", {63'd0, if_id_valid},       64'd1);
        check("post_pc",    if_id_pc,                   64'h0);
        check("post_instr", {32'd0, if_id_instruction}, {32'd0, word_at(64'h0)});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, 64'h0, word-aligned address of the first fetch after reset.
REQ-002 Parameter NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0) written into IF/ID on flush.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 hazard_detected  in  1  load-use stall from decode; hold PC and IF/ID.
REQ-006 flush  in  1  taken-branch redirect from decode.
REQ-007 branch_target  in  64  redirect address, sampled only when flush=1.
REQ-008 imem_req  out  1  fetch request valid.
REQ-009 imem_addr  out  64  fetch address.
REQ-010 imem_rdata  in  32  returned instruction word.
REQ-011 imem_valid  in  1  imem_rdata valid; may assert in the same cycle as imem_req (zero-wait) or any later cycle.
REQ-012 if_id_instruction  out  32  IF/ID instruction to decode.
REQ-013 if_id_pc  out  64  PC of if_id_instruction.
REQ-014 if_id_valid  out  1  IF/ID holds a real instruction.
REQ-015 fetch_misaligned  out  1  one-cycle pulse when a redirect target has bits[1:0]!=0.

Function
REQ-016 FSM states SHALL be REQ (request outstanding), HOLD (word captured in one-entry skid buffer during stall), DRAIN (discarding a stale outstanding response after flush).
REQ-017 At most one request SHALL be outstanding; imem_addr SHALL stay stable while imem_req=1 and imem_valid=0.
REQ-018 REQ, imem_valid=1, no stall, no flush: IF/ID <= {imem_rdata, pc, valid=1}, pc <= pc+4, stay REQ; sustains one instruction per cycle with zero-wait memory.
REQ-019 REQ, imem_valid=1, hazard_detected=1: IF/ID unchanged, word and pc captured in skid buffer, imem_req=0 next cycle, go HOLD.
REQ-020 REQ, imem_valid=0, hazard_detected=1: IF/ID unchanged, request remains outstanding.
REQ-021 HOLD, hazard_detected=0: skid buffer moves to IF/ID, pc <= pc+4, go REQ; no memory access in HOLD.
REQ-022 flush=1 (any state) SHALL win over hazard_detected and imem_valid: IF/ID <= {NOP_INSTR, pc unchanged, valid=0}, skid buffer cleared, pc <= {branch_target[63:2],2'b00}.
REQ-023 flush while a request is outstanding and imem_valid=0: go DRAIN with imem_req=0; the next imem_valid is discarded, then go REQ at the new pc.
REQ-024 flush with imem_valid=1 in the same cycle, or in HOLD: the word is discarded and the state goes directly to REQ.
REQ-025 flush with branch_target[1:0]!=0 SHALL pulse fetch_misaligned for exactly one cycle; redirect still proceeds with bits[1:0] cleared.
REQ-026 pc+4 SHALL wrap modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC -> 64'h0) with no flag.
REQ-027 imem_valid while no request is outstanding SHALL be ignored.
REQ-028 imem_req SHALL be 1 in REQ and 0 in HOLD and DRAIN.

Reset
REQ-029 While rst_n=0: pc=RESET_PC, state=REQ, imem_req=0, if_id_instruction=NOP_INSTR, if_id_pc=0, if_id_valid=0, skid buffer empty, fetch_misaligned=0.
REQ-030 Assertion mid-request SHALL abandon it; the first request after deassertion SHALL be to RESET_PC on the first rising edge.

Structure
REQ-031 Shared package riscv_pkg SHALL hold XLEN=64, ILEN=32, NOP_INSTR, and the fetch FSM state enum.
REQ-032 The IF/ID register SHALL be a sub-module if_id_reg (hold, flush-to-NOP, load).

Verification
REQ-033 Zero-wait memory, reset release: if_id_pc = 0, 4, 8, 12 on four consecutive cycles, if_id_valid=1.
REQ-034 hazard_detected=1 for 3 cycles with a word returned: IF/ID frozen, imem_req=0; after release the held word appears once and no duplicate or skipped PC occurs.
REQ-035 2-cycle-latency memory, flush to 64'h100 one cycle after the request: the stale word is discarded (DRAIN), the next IF/ID pc is 64'h100, and one NOP bubble with valid=0 precedes it.
REQ-036 flush and hazard_detected together with branch_target=64'h203: fetch_misaligned pulses once, next fetch address is 64'h200.
REQ-037 pc=64'hFFFF_FFFF_FFFF_FFFC fetched: next imem_addr is 64'h0.
REQ-038 rst_n asserted mid-request: outputs reach reset values asynchronously; first imem_addr after release equals RESET_PC.
